// File: rtl/base_cfifo.sv
// RAM-backed valid/ready FIFO with registered output beat, occupancy count, credit-slack ready and flush.
// Latency 2 cycles write->o_v; i_r is advisory only: beats are stored while the array has room.
// Optional sticky overflow flag err is built only when BASE_CFIFO_ERR_EN is defined.
module base_cfifo #(
    parameter int    width     = 1,
    parameter int    LOG_DEPTH = 3,
    parameter int    DEPTH     = 2**LOG_DEPTH,
    parameter int    SLACK     = 2,
    parameter string ramstyle  = "no_rw_check"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             i_v,
    input  logic [width-1:0] i_d,
    output logic             i_r,
    output logic             o_v,
    output logic [width-1:0] o_d,
    input  logic             o_r,
    output logic [LOG_DEPTH:0] cnt,
    output logic             empty
`ifdef BASE_CFIFO_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int CW = LOG_DEPTH + 1;
    localparam int PW = LOG_DEPTH;
    localparam logic [CW-1:0] ARR_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - SLACK);

    (* ramstyle = ramstyle *) logic [width-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] arr_cnt, arr_cnt_next, cnt_next;
    logic          arr_full, acc, ld, pop;

    always_comb begin
        arr_full     = (arr_cnt == ARR_MAX);
        acc          = i_v & ~arr_full;
        ld           = (arr_cnt != '0) & (~o_v | o_r);
        pop          = o_v & o_r;
        arr_cnt_next = arr_cnt + CW'(acc) - CW'(ld);
        cnt_next     = flush ? '0 : (cnt + CW'(acc) - CW'(pop));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            arr_cnt <= '0;
            cnt     <= '0;
            o_v     <= 1'b0;
            i_r     <= 1'b1;
            empty   <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                arr_cnt <= '0;
                o_v     <= 1'b0;
            end else begin
                if (acc) wr_ptr <= wr_ptr + PW'(1);
                if (ld)  rd_ptr <= rd_ptr + PW'(1);
                arr_cnt <= arr_cnt_next;
                o_v     <= ld | (o_v & ~o_r);
            end
            cnt   <= cnt_next;
            i_r   <= (cnt_next <= RDY_MAX);
            empty <= (cnt_next == '0);
        end
    end

    // Read and write never hit the same entry: a load needs a non-empty array,
    // and a write needs a non-full one, so rd_ptr == wr_ptr cannot coincide with both.
    always_ff @(posedge clk) begin
        if (acc) mem[wr_ptr] <= i_d;
        if (ld)  o_d <= mem[rd_ptr];
    end

`ifdef BASE_CFIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else if (i_v & arr_full)
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_base_cfifo.sv
// Self-checking bench for base_cfifo (width=8, LOG_DEPTH=3, SLACK=2): directed scenarios plus random traffic.
module tb_base_cfifo;

    localparam int DEPTH = 8;
    localparam int SLACK = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       i_v = 1'b0;
    logic [7:0] i_d = '0;
    logic       i_r;
    logic       o_v;
    logic [7:0] o_d;
    logic       o_r = 1'b0;
    logic [3:0] cnt;
    logic       empty;
`ifdef BASE_CFIFO_ERR_EN
    logic       err;
`endif

    base_cfifo #(.width(8), .LOG_DEPTH(3), .SLACK(SLACK)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .i_v(i_v), .i_d(i_d), .i_r(i_r),
        .o_v(o_v), .o_d(o_d), .o_r(o_r),
        .cnt(cnt), .empty(empty)
`ifdef BASE_CFIFO_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: beats in arrival order, each stamped with its write cycle.
    // A beat is visible at the head once it has spent at least one cycle in the array.
    typedef struct {
        logic [7:0] d;
        int         wr;
    } beat_t;

    beat_t q[$];
    int    cyc = 0;
    bit    m_err = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;
    int    pops = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_ov();
        return (q.size() > 0) && (q[0].wr <= cyc - 2);
    endfunction

    // Compare DUT against the model, apply one cycle of inputs, advance the model.
    task automatic step(input bit iv, input logic [7:0] d, input bit orr, input bit fl, input bit rs);
        bit    ov, afull, acc, pop;
        beat_t b;
        ov = m_ov();
        check("o_v", {31'd0, o_v}, {31'd0, ov});
        if (ov) check("o_d", {24'd0, o_d}, {24'd0, q[0].d});
        check("cnt", {28'd0, cnt}, q.size());
        check("i_r", {31'd0, i_r}, {31'd0, q.size() <= DEPTH - SLACK});
        check("empty", {31'd0, empty}, {31'd0, q.size() == 0});
`ifdef BASE_CFIFO_ERR_EN
        check("err", {31'd0, err}, {31'd0, m_err});
`endif
        if (o_v === 1'b1 && orr) pops++;
        i_v = iv; i_d = d; o_r = orr; flush = fl; reset = rs;
        @(posedge clk);
        afull = (q.size() - int'(ov)) == DEPTH;
        if (rs) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (iv && afull) m_err = 1'b1;
            if (fl) begin
                q.delete();
            end else begin
                acc = iv && !afull;
                pop = ov && orr;
                if (pop) void'(q.pop_front());
                if (acc) begin
                    b.d = d;
                    b.wr = cyc;
                    q.push_back(b);
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        // Initial reset, outside step() since the DUT is unknown before it.
        repeat (2) @(posedge clk);
        q.delete();
        cyc = 2;
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0, 0, 0);

        // 1: reset state, then one beat with 2-cycle latency
        check("rst_o_v", {31'd0, o_v}, 0);
        check("rst_i_r", {31'd0, i_r}, 1);
        check("rst_cnt", {28'd0, cnt}, 0);
        check("rst_empty", {31'd0, empty}, 1);
        step(1, 8'h11, 0, 0, 0);
        check("lat_o_v_n1", {31'd0, o_v}, 0);
        step(0, 0, 0, 0, 0);
        check("lat_o_v", {31'd0, o_v}, 1);
        check("lat_o_d", {24'd0, o_d}, 32'h11);
        check("lat_cnt", {28'd0, cnt}, 1);
        step(0, 0, 1, 0, 0);

        // 2/3: fill to capacity with o_r low, drop an extra beat, drain in order
        for (int i = 0; i < 9; i++) step(1, 8'(i), 0, 0, 0);
        check("full_cnt", {28'd0, cnt}, 9);
        check("full_i_r", {31'd0, i_r}, 0);
        step(1, 8'hAA, 0, 0, 0);
        check("drop_cnt", {28'd0, cnt}, 9);
`ifdef BASE_CFIFO_ERR_EN
        check("drop_err", {31'd0, err}, 1);
`endif
        for (int i = 0; i < 9; i++) begin
            check("drain_o_d", {24'd0, o_d}, i);
            step(0, 0, 1, 0, 0);
        end
        check("drain_empty", {31'd0, empty}, 1);
        check("drain_i_r", {31'd0, i_r}, 1);
        for (int i = 0; i < 9; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'hAA, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("flush_cnt", {28'd0, cnt}, 0);
`ifdef BASE_CFIFO_ERR_EN
        check("err_after_flush", {31'd0, err}, 1);
`endif

        // 4: streaming, one beat per cycle
        pops = 0;
        for (int i = 0; i < 100; i++) step(1, 8'(i), 1, 0, 0);
        check("stream_pops", pops, 98);
        check("stream_cnt", {28'd0, cnt}, 2);
        check("stream_o_v", {31'd0, o_v}, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // 5: flush with a same-cycle write
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        check("pre_flush_cnt", {28'd0, cnt}, 5);
        step(1, 8'hEE, 0, 1, 0);
        check("flush_o_v", {31'd0, o_v}, 0);
        check("flush_cnt2", {28'd0, cnt}, 0);
        check("flush_i_r", {31'd0, i_r}, 1);
        step(1, 8'h5A, 0, 0, 0);
        check("post_flush_o_v_n1", {31'd0, o_v}, 0);
        step(0, 0, 0, 0, 0);
        check("post_flush_o_v", {31'd0, o_v}, 1);
        check("post_flush_o_d", {24'd0, o_d}, 32'h5A);

        // 6: reset while full, then random traffic with varying consumer rate
        for (int i = 0; i < 9; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'h77, 1, 0, 1);
        check("rst_mid_o_v", {31'd0, o_v}, 0);
        check("rst_mid_cnt", {28'd0, cnt}, 0);
`ifdef BASE_CFIFO_ERR_EN
        check("rst_mid_err", {31'd0, err}, 0);
`endif
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, 3) != 0,
                     8'($urandom),
                     $urandom_range(0, 3) < p,
                     $urandom_range(0, 99) == 0,
                     $urandom_range(0, 299) == 0);
            end
        end
        step(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
